// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Operation codes follow the MIPS MULT/MULTU/DIV/DIVU ordering.
package mdu_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate.
// Serves both as |x| for operands and as sign restore for results.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// Magnitudes are processed unsigned; signs are restored in FIX.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mdu_pkg::*;

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(ITER);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             sign_q, sign_d;
  logic             rsign_q, rsign_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             in_signed;
  logic [WIDTH-1:0] abs1, abs2;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quot, rem;
  logic [WIDTH:0]   add_sum;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [W2-1:0]    mul_next, div_next;

  assign in_signed = ~op[0];

  mdu_sign_fix #(.W(WIDTH)) u_abs1 (
    .val_i (in1),
    .neg_i (in_signed & in1[WIDTH-1]),
    .val_o (abs1)
  );

  mdu_sign_fix #(.W(WIDTH)) u_abs2 (
    .val_i (in2),
    .neg_i (in_signed & in2[WIDTH-1]),
    .val_o (abs2)
  );

  mdu_sign_fix #(.W(W2)) u_prod (
    .val_i (acc_q),
    .neg_i (sign_q),
    .val_o (prod)
  );

  mdu_sign_fix #(.W(WIDTH)) u_quot (
    .val_i (acc_q[WIDTH-1:0]),
    .neg_i (sign_q),
    .val_o (quot)
  );

  mdu_sign_fix #(.W(WIDTH)) u_rem (
    .val_i (acc_q[W2-1:WIDTH]),
    .neg_i (rsign_q),
    .val_o (rem)
  );

  // Shift-add: upper half accumulates, multiplier drains out the bottom
  assign add_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[W2-1:1]};

  // Restoring divide: {rem, quot} shifts left, quotient bit enters at 0
  assign rem_ge   = acc_q[W2-1:WIDTH-1] >= {1'b0, opnd_q};
  assign rem_sub  = acc_q[W2-2:WIDTH-1] - opnd_q;
  assign div_next = rem_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                           : {acc_q[W2-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sign_d  = sign_q;
    rsign_d = rsign_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (start) begin
          div_d   = op[1];
          sign_d  = in_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
          rsign_d = (op == OP_DIV) & in1[WIDTH-1];
          opnd_d  = op[1] ? abs2 : abs1;
          acc_d   = op[1] ? {{WIDTH{1'b0}}, abs1}
                          : {{WIDTH{1'b0}}, abs2};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          dbz_d = (opnd_q == '0);
          hi_d  = rem;
          lo_d  = (opnd_q == '0) ? '1 : quot;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sign_q  <= 1'b0;
      rsign_q <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sign_q  <= sign_d;
      rsign_q <= rsign_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit.
// Expected HI/LO/div_by_zero are queued at issue and popped at done.
module tb_mult_div_unit;

  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .in1         (in1),
    .in2         (in2),
    .wr_hi       (wr_hi),
    .wr_lo       (wr_lo),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } res_t;

  res_t        scb[$];
  int          n_chk = 0;
  int          n_fail = 0;

  res_t        obs;
  int          o_lat, o_busy;
  bit          o_to;
  logic [31:0] o_lo_poke;

  function automatic res_t mk(input logic [31:0] h, input logic [31:0] l,
                              input logic z);
    res_t r;
    r.hi = h; r.lo = l; r.dbz = z;
    return r;
  endfunction

  function automatic res_t model(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    int          sa, sb;
    res_t        r;
    sa = a;
    sb = b;
    r = '0;
    case (o)
      2'b00: begin
        p = longint'(sa) * longint'(sb);
        u = p;
        r = mk(u[63:32], u[31:0], 1'b0);
      end
      2'b01: begin
        u = {32'b0, a} * {32'b0, b};
        r = mk(u[63:32], u[31:0], 1'b0);
      end
      2'b10: r = mk(32'(sa % sb), 32'(sa / sb), 1'b0);
      default: r = mk(a % b, a / b, 1'b0);
    endcase
    return r;
  endfunction

  // Drives one operation and records what the DUT produced
  task automatic issue(input logic [1:0] t_op, input logic [31:0] a,
                       input logic [31:0] b, input res_t exp,
                       input int poke_at);
    scb.push_back(exp);
    @(negedge clk);
    op = t_op; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in1 = ~a; in2 = ~b;
    o_lat = 0; o_busy = 0; o_to = 1'b1; obs = '0; o_lo_poke = lo;
    for (int k = 0; k < 60; k++) begin
      if (busy) o_busy++;
      if (done) begin
        o_to = 1'b0;
        obs = mk(hi, lo, div_by_zero);
        break;
      end
      if (k == poke_at) begin
        start = 1'b1; op = OP_DIV; in1 = 32'h1234; in2 = 32'h7;
        wr_lo = 1'b1; wr_data = 32'hAAAA5555;
      end
      @(posedge clk); #1;
      if (k == poke_at) o_lo_poke = lo;
      start = 1'b0; wr_lo = 1'b0;
      o_lat++;
    end
  endtask

  task automatic test_reset();
    n_chk++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b exp 000", {busy, done, div_by_zero});
    end
    n_chk++;
    if ({hi, lo} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_hilo: got %h_%h exp 0", hi, lo);
    end
  endtask

  task automatic test_mult();
    res_t e;
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7, mk(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0), -1);
    e = scb.pop_front();
    n_chk++;
    if (o_to || obs !== e) begin
      n_fail++;
      $display("FAIL mult: got %h to=%0d exp %h", obs, o_to, e);
    end
    n_chk++;
    if (o_lat != 33) begin
      n_fail++;
      $display("FAIL mult_latency: got %0d exp 33 edges after capture", o_lat);
    end
    n_chk++;
    if (o_busy != 33) begin
      n_fail++;
      $display("FAIL mult_busy_cycles: got %0d exp 33", o_busy);
    end
    @(posedge clk); #1;
    n_chk++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_multu();
    res_t e;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'hFFFFFFFE, 32'h1, 1'b0), -1);
    e = scb.pop_front();
    n_chk++;
    if (o_to || obs !== e) begin
      n_fail++;
      $display("FAIL multu: got %h to=%0d exp %h", obs, o_to, e);
    end
  endtask

  task automatic test_div();
    res_t e;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, mk(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0), -1);
    e = scb.pop_front();
    n_chk++;
    if (o_to || obs !== e) begin
      n_fail++;
      $display("FAIL div_signed: got %h to=%0d exp %h", obs, o_to, e);
    end
    issue(OP_DIVU, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0), -1);
    e = scb.pop_front();
    n_chk++;
    if (o_to || obs !== e) begin
      n_fail++;
      $display("FAIL divu: got %h to=%0d exp %h", obs, o_to, e);
    end
  endtask

  task automatic test_div_zero();
    res_t e;
    issue(OP_DIVU, 32'h12345678, 32'h0, mk(32'h12345678, 32'hFFFFFFFF, 1'b1), -1);
    e = scb.pop_front();
    n_chk++;
    if (o_to || obs !== e) begin
      n_fail++;
      $display("FAIL divu_zero: got %h to=%0d exp %h", obs, o_to, e);
    end
    n_chk++;
    if (o_lat != 33) begin
      n_fail++;
      $display("FAIL div_zero_latency: got %0d exp 33", o_lat);
    end
    @(posedge clk); #1;
    n_chk++;
    if (div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_clear: got %b exp 0", div_by_zero);
    end
  endtask

  task automatic test_overflow();
    res_t e;
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, mk(32'h0, 32'h80000000, 1'b0), -1);
    e = scb.pop_front();
    n_chk++;
    if (o_to || obs !== e) begin
      n_fail++;
      $display("FAIL div_overflow: got %h to=%0d exp %h", obs, o_to, e);
    end
  endtask

  task automatic test_busy_ignore();
    res_t        e;
    logic [31:0] lo_before;
    lo_before = lo;
    issue(OP_MULTU, 32'd6, 32'd7, mk(32'h0, 32'd42, 1'b0), 5);
    e = scb.pop_front();
    n_chk++;
    if (o_lo_poke !== lo_before) begin
      n_fail++;
      $display("FAIL busy_wr_lo: got %h exp %h", o_lo_poke, lo_before);
    end
    n_chk++;
    if (o_to || obs !== e || o_lat != 33) begin
      n_fail++;
      $display("FAIL busy_start: got %h lat=%0d exp %h lat=33", obs, o_lat, e);
    end
    @(posedge clk); #1;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_requeue: got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_wr();
    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'hAAAA5555;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    n_chk++;
    if (lo !== 32'hAAAA5555) begin
      n_fail++;
      $display("FAIL wr_lo: got %h exp aaaa5555", lo);
    end
    @(negedge clk);
    wr_lo = 1'b1; wr_hi = 1'b1; wr_data = 32'h0F0F1234;
    @(posedge clk); #1;
    wr_lo = 1'b0; wr_hi = 1'b0;
    n_chk++;
    if ({hi, lo} !== {32'h0F0F1234, 32'h0F0F1234}) begin
      n_fail++;
      $display("FAIL wr_both: got %h_%h exp 0f0f1234_0f0f1234", hi, lo);
    end
  endtask

  task automatic test_reset_abort();
    res_t e;
    int   n_done;
    @(negedge clk);
    op = OP_MULT; in1 = 32'h1234; in2 = 32'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      n_fail++;
      $display("FAIL abort_state: got busy=%b done=%b %h_%h exp 0",
               busy, done, hi, lo);
    end
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    n_chk++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done pulses exp 0", n_done);
    end
    issue(OP_MULTU, 32'd9, 32'd9, mk(32'h0, 32'd81, 1'b0), -1);
    e = scb.pop_front();
    n_chk++;
    if (o_to || obs !== e) begin
      n_fail++;
      $display("FAIL after_abort: got %h to=%0d exp %h", obs, o_to, e);
    end
  endtask

  task automatic test_random();
    res_t        e;
    logic [1:0]  ro;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      ro = 2'(i % 4);
      a = $urandom;
      b = $urandom;
      if (i >= 4) b = b >> $urandom_range(0, 28);
      if (b == 0) b = 32'd3;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd5;
      issue(ro, a, b, model(ro, a, b), -1);
      e = scb.pop_front();
      n_chk++;
      if (o_to || obs !== e) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h exp %h",
                 i, ro, a, b, obs, e);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_overflow();
    test_busy_ignore();
    test_wr();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
